// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line in, received word and status pulses out
// serial_data_in : idle-high serial line driven by the master
// rx_data_out    : last good received word
// rx_valid       : one-cycle pulse when rx_data_out is updated
// framing_error  : one-cycle pulse when the stop bit is sampled low
// rx_busy        : high whenever the receiver is not idle
interface uart_rx_sampler_if #(parameter int DATA_SIZE = 8);
  logic                 serial_data_in;
  logic [DATA_SIZE-1:0] rx_data_out;
  logic                 rx_valid;
  logic                 framing_error;
  logic                 rx_busy;
  modport master (output serial_data_in, input rx_data_out, rx_valid, framing_error, rx_busy);
  modport slave  (input serial_data_in, output rx_data_out, rx_valid, framing_error, rx_busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver, LSB first, no parity, one stop bit
// clk     : system clock, rising edge
// reset_n : asynchronous active-low reset
// bus     : slave side of uart_rx_sampler_if (serial in; word, valid, framing error, busy out)
module uart_rx_sampler #(
  parameter int DATA_SIZE      = 8,
  parameter int OVERSAMPLE     = 16,
  parameter int BAUD_DIV       = 27,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_rx_sampler_if.slave bus
);
  localparam int DIV_W  = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0]          DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [SAMP_W-1:0]         SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0]         SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_COUNT_SIZE-1:0] BIT_LAST  = BIT_COUNT_SIZE'(DATA_SIZE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t                    state_q, state_d;
  logic [1:0]                sync_q, sync_d;
  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [SAMP_W-1:0]         samp_cnt_q, samp_cnt_d;
  logic [BIT_COUNT_SIZE-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]      shift_q, shift_d;
  logic [DATA_SIZE-1:0]      data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      rx_s, tick, centre, hold;
  assign rx_s = sync_q[1];
  always_comb begin
    sync_d     = {sync_q[0], bus.serial_data_in};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tick       = div_cnt_q == DIV_LAST;
    centre     = tick && samp_cnt_q == SAMP_LAST;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START: if (tick && samp_cnt_q == SAMP_MID) begin
        // a start bit still low at its middle is real; the state change re-centres the counters
        state_d   = rx_s ? IDLE : DATA;
        bit_cnt_d = '0;
      end
      DATA: if (centre) begin
        shift_d   = {rx_s, shift_q[DATA_SIZE-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) state_d = STOP;
      end
      STOP: if (centre) begin
        data_d  = rx_s ? shift_q : data_q;
        valid_d = rx_s;
        ferr_d  = !rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    hold       = state_q == IDLE || state_q == WAIT_IDLE || state_d != state_q;
    div_cnt_d  = (hold || tick) ? '0 : div_cnt_q + 1'b1;
    samp_cnt_d = hold ? '0 : !tick ? samp_cnt_q : samp_cnt_q == SAMP_LAST ? '0 : samp_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      div_cnt_q  <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      div_cnt_q  <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end
  assign bus.rx_data_out   = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.framing_error = ferr_q;
  assign bus.rx_busy       = state_q != IDLE;
endmodule
